// File: rtl/vote_tally_pkg.sv
// Shared types and constants for the weighted shareholder vote tally.
package vote_tally_pkg;

    // Width of every share quantity (weights, accumulator, threshold).
    localparam int unsigned ShareW = 7;

    // Default shareholder weights in percent and the pass threshold.
    localparam int unsigned DefWeightA = 45;
    localparam int unsigned DefWeightB = 30;
    localparam int unsigned DefWeightC = 15;
    localparam int unsigned DefWeightD = 10;
    localparam int unsigned DefThresh  = 51;

    typedef enum logic {
        StCollect,
        StResult
    } state_e;

endpackage

// File: rtl/vote_tally.sv
// Weighted vote tally: collects four ordered votes (A, B, C, D), sums the
// yes-shares, and presents a pass/fail result until the consumer takes it.
module vote_tally
    import vote_tally_pkg::*;
#(
    parameter int unsigned W_A    = DefWeightA,
    parameter int unsigned W_B    = DefWeightB,
    parameter int unsigned W_C    = DefWeightC,
    parameter int unsigned W_D    = DefWeightD,
    parameter int unsigned THRESH = DefThresh
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vote_valid,
    input  logic              vote_bit,
    output logic              vote_ready,
    input  logic              abort,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_pass,
    output logic [ShareW-1:0] res_shares,
    output logic [3:0]        res_mask,
    output logic [7:0]        ballot_count
);

    localparam int unsigned Total = W_A + W_B + W_C + W_D;
    localparam logic [ShareW-1:0] ThreshS = ShareW'(THRESH);

    // Parameter sanity: the sum must fit the share width and the threshold
    // must be reachable.
    if (Total > 127) begin : g_bad_total
        $error("vote_tally: weight sum %0d exceeds 127", Total);
    end
    if (THRESH > Total) begin : g_bad_thresh
        $error("vote_tally: THRESH %0d exceeds weight sum %0d", THRESH, Total);
    end

    state_e            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [ShareW-1:0] acc_q, acc_d;
    logic [3:0]        mask_q, mask_d;
    logic              pass_q, pass_d;
    logic [7:0]        count_q, count_d;
    logic              live_q;
    logic [ShareW-1:0] weight;
    logic              accept;

    // Weight of the shareholder whose vote is expected next.
    always_comb begin
        weight = '0;
        unique case (idx_q)
            2'd0: weight = ShareW'(W_A);
            2'd1: weight = ShareW'(W_B);
            2'd2: weight = ShareW'(W_C);
            2'd3: weight = ShareW'(W_D);
        endcase
    end

    // live_q holds vote_ready low through reset and until the first clock edge.
    assign vote_ready = live_q && (state_q == StCollect);
    assign accept     = vote_valid && vote_ready;

    // Next-state: vote accumulation, result handshake and abort handling.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        mask_d  = mask_q;
        count_d = count_q;
        unique case (state_q)
            StCollect: begin
                if (abort) begin
                    // Abort wins over a simultaneous vote.
                    idx_d  = 2'd0;
                    acc_d  = '0;
                    mask_d = '0;
                end else if (accept) begin
                    if (vote_bit) begin
                        acc_d = acc_q + weight;
                    end
                    mask_d[2'd3 - idx_q] = vote_bit;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = StResult;
                    end
                end
            end
            StResult: begin
                if (abort || res_ready) begin
                    state_d = StCollect;
                    idx_d   = 2'd0;
                    acc_d   = '0;
                    mask_d  = '0;
                    // Abort drops the result without counting it.
                    if (!abort) begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            default: state_d = StCollect;
        endcase
        pass_d = (acc_d >= ThreshS);
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StCollect;
            idx_q   <= 2'd0;
            acc_q   <= '0;
            mask_q  <= '0;
            pass_q  <= 1'b0;
            count_q <= 8'd0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
            count_q <= count_d;
            live_q  <= 1'b1;
        end
    end

    assign res_valid    = (state_q == StResult);
    assign res_pass     = pass_q;
    assign res_shares   = acc_q;
    assign res_mask     = mask_q;
    assign ballot_count = count_q;

endmodule

// File: tb/tb_vote_tally.sv
// Self-checking bench for vote_tally: directed vectors, corner sequences and
// randomized ballots against a percentage-sum reference model.
module tb_vote_tally;
    import vote_tally_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vote_valid = 1'b0;
    logic       vote_bit = 1'b0;
    logic       abort = 1'b0;
    logic       res_ready = 1'b0;
    logic       vote_ready;
    logic       res_valid;
    logic       res_pass;
    logic [6:0] res_shares;
    logic [3:0] res_mask;
    logic [7:0] ballot_count;

    vote_tally dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vote_valid   (vote_valid),
        .vote_bit     (vote_bit),
        .vote_ready   (vote_ready),
        .abort        (abort),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_pass     (res_pass),
        .res_shares   (res_shares),
        .res_mask     (res_mask),
        .ballot_count (ballot_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int model_count = 0;
    int wts[4] = '{45, 30, 15, 10};

    typedef struct {
        logic [3:0] votes;
        int         shares;
        int         pass;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: yes-share total is the sum of weights of shareholders voting yes.
    function automatic int ref_shares(input logic [3:0] v);
        int s = 0;
        for (int i = 0; i < 4; i++) begin
            if (v[3-i]) s += wts[i];
        end
        return s;
    endfunction

    task automatic do_vote(input logic b, input int gap);
        int g = 0;
        vote_valid = 1'b0;
        for (int k = 0; k < gap; k++) tick();
        vote_valid = 1'b1;
        vote_bit   = b;
        while (!vote_ready && g < 20) begin
            tick();
            g++;
        end
        if (g == 20) chk("vote_ready_timeout", 0, 1);
        tick();
        vote_valid = 1'b0;
    endtask

    // Offers four votes and checks partial sums and the final result.
    task automatic run_ballot(input logic [3:0] v, input int max_gap);
        int partial = 0;
        for (int i = 0; i < 4; i++) begin
            do_vote(v[3-i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            if (v[3-i]) partial += wts[i];
            if (i < 3) begin
                chk("partial_shares", int'(res_shares), partial);
                chk("partial_valid", int'(res_valid), 0);
            end
        end
        chk("res_valid", int'(res_valid), 1);
        chk("res_shares", int'(res_shares), ref_shares(v));
        chk("res_pass", int'(res_pass), (ref_shares(v) >= 51) ? 1 : 0);
        chk("res_mask", int'(res_mask), int'(v));
        chk("ready_in_result", int'(vote_ready), 0);
    endtask

    task automatic take_result(input int stall);
        res_ready = 1'b0;
        for (int k = 0; k < stall; k++) tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        model_count = (model_count + 1) % 256;
        chk("ballot_count", int'(ballot_count), model_count);
        chk("ready_after_take", int'(vote_ready), 1);
        chk("valid_after_take", int'(res_valid), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        vecs = '{
            '{4'b1000, 45, 0}, '{4'b1001, 55, 1}, '{4'b0111, 55, 1},
            '{4'b0110, 45, 0}, '{4'b1100, 75, 1}, '{4'b0000, 0, 0},
            '{4'b1111, 100, 1}, '{4'b0101, 40, 0}, '{4'b1010, 60, 1}
        };

        // Reset state, then release between clock edges.
        #2;
        chk("rst_valid", int'(res_valid), 0);
        chk("rst_pass", int'(res_pass), 0);
        chk("rst_shares", int'(res_shares), 0);
        chk("rst_mask", int'(res_mask), 0);
        chk("rst_count", int'(ballot_count), 0);
        chk("rst_ready", int'(vote_ready), 0);
        #20 rst_n = 1'b1;
        chk("ready_before_edge", int'(vote_ready), 0);
        tick();
        chk("ready_first_edge", int'(vote_ready), 1);

        // Directed table of ballots.
        foreach (vecs[i]) begin
            run_ballot(vecs[i].votes, 0);
            chk("tbl_shares", int'(res_shares), vecs[i].shares);
            chk("tbl_pass", int'(res_pass), vecs[i].pass);
            take_result(0);
        end

        // Held result with vote_valid asserted: nothing moves, no vote taken.
        run_ballot(4'b1001, 0);
        vote_valid = 1'b1;
        vote_bit   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_valid", int'(res_valid), 1);
            chk("hold_shares", int'(res_shares), 55);
            chk("hold_pass", int'(res_pass), 1);
            chk("hold_mask", int'(res_mask), 9);
            chk("hold_ready", int'(vote_ready), 0);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        model_count = (model_count + 1) % 256;
        chk("hold_count", int'(ballot_count), model_count);
        chk("hold_ready_after", int'(vote_ready), 1);
        chk("hold_mask_cleared", int'(res_mask), 0);
        vote_valid = 1'b0;

        // Abort with a simultaneous vote after two votes.
        do_vote(1'b1, 0);
        do_vote(1'b1, 0);
        vote_valid = 1'b1;
        vote_bit   = 1'b1;
        abort      = 1'b1;
        tick();
        abort      = 1'b0;
        vote_valid = 1'b0;
        chk("abort_shares", int'(res_shares), 0);
        chk("abort_mask", int'(res_mask), 0);
        chk("abort_count", int'(ballot_count), model_count);
        run_ballot(4'b1100, 0);
        chk("fresh_shares", int'(res_shares), 75);
        take_result(0);

        // Abort together with res_ready drops the result uncounted.
        run_ballot(4'b1111, 0);
        abort     = 1'b1;
        res_ready = 1'b1;
        tick();
        abort     = 1'b0;
        res_ready = 1'b0;
        chk("abort_res_valid", int'(res_valid), 0);
        chk("abort_res_count", int'(ballot_count), model_count);
        chk("abort_res_ready", int'(vote_ready), 1);

        // Asynchronous reset mid-ballot.
        do_vote(1'b1, 0);
        do_vote(1'b1, 0);
        do_vote(1'b1, 0);
        #2 rst_n = 1'b0;
        #1;
        model_count = 0;
        chk("arst_shares", int'(res_shares), 0);
        chk("arst_mask", int'(res_mask), 0);
        chk("arst_pass", int'(res_pass), 0);
        chk("arst_valid", int'(res_valid), 0);
        chk("arst_count", int'(ballot_count), 0);
        chk("arst_ready", int'(vote_ready), 0);
        #3 rst_n = 1'b1;
        chk("arst_ready_pre_edge", int'(vote_ready), 0);
        tick();
        chk("arst_ready_edge", int'(vote_ready), 1);
        run_ballot(4'b0000, 0);
        chk("arst_fresh_shares", int'(res_shares), 0);
        chk("arst_fresh_pass", int'(res_pass), 0);
        take_result(0);

        // All 16 patterns against the majority formula.
        for (int p = 0; p < 16; p++) begin
            logic [3:0] v;
            int exp_pass;
            v = 4'(p);
            exp_pass = int'((v[3] & (v[2] | v[1] | v[0])) | (v[2] & v[1] & v[0]));
            run_ballot(v, 0);
            chk("formula_pass", int'(res_pass), exp_pass);
            take_result(0);
        end

        // Randomized ballots with gaps, stalls and occasional aborts.
        for (int n = 0; n < 40; n++) begin
            logic [3:0] v;
            v = 4'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                do_vote(1'($urandom), 0);
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("rand_abort_shares", int'(res_shares), 0);
            end
            run_ballot(v, 2);
            take_result(int'($urandom_range(0, 3)));
        end

        // Run ballots until the counter wraps through 255 to 0.
        begin
            int guard = 0;
            while (model_count != 0 && guard < 300) begin
                run_ballot(4'($urandom), 0);
                take_result(0);
                guard++;
            end
            chk("count_wrap", int'(ballot_count), 0);
            chk("wrap_model", model_count, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
